// File: rtl/dense_pkg.sv
// Shared types and defaults for the dense-layer sequencing block.
package dense_pkg;
  localparam int DATA_SIZE  = 16;
  localparam int SIZE       = 3;
  localparam int MAX_LAYERS = 8;
  localparam int IDX_W      = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE_W, S_FWD, S_BPROP, S_UPD, S_DONE
  } dense_seq_state_t;

  // Op bundle ordering: {load_w, backprop_cost, is_update}.
  typedef logic [2:0] op_t;
  localparam op_t OP_NONE  = 3'b000;
  localparam op_t OP_LOAD  = 3'b100;
  localparam op_t OP_BPROP = 3'b010;
  localparam op_t OP_UPD   = 3'b001;

  function automatic op_t state_op(input dense_seq_state_t s);
    case (s)
      S_ISSUE_W: return OP_LOAD;
      S_BPROP:   return OP_BPROP;
      S_UPD:     return OP_UPD;
      default:   return OP_NONE;
    endcase
  endfunction
endpackage

// File: rtl/dense_idx_counter.sv
// Nested layer/row counter: rows wrap into the next layer; last_o flags the final (layer,row).
module dense_idx_counter
  import dense_pkg::*;
#(
  parameter int IW = IDX_W
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          step_i,
  input  logic [IW-1:0] num_layers_i,
  input  logic [IW-1:0] num_rows_i,
  output logic [IW-1:0] layer_o,
  output logic [IW-1:0] row_o,
  output logic          last_o
);
  localparam logic [IW-1:0] ONE = IW'(1);

  logic [IW-1:0] layer_q, layer_d, row_q, row_d;

  always_comb begin
    layer_d = layer_q;
    row_d   = row_q;
    if (clr_i) begin
      layer_d = '0;
      row_d   = '0;
    end else if (step_i) begin
      if (row_q == num_rows_i - ONE) begin
        row_d   = '0;
        layer_d = layer_q + ONE;
      end else begin
        row_d = row_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      layer_q <= '0;
      row_q   <= '0;
    end else begin
      layer_q <= layer_d;
      row_q   <= row_d;
    end
  end

  assign layer_o = layer_q;
  assign row_o   = row_q;
  assign last_o  = (layer_q == num_layers_i - ONE) && (row_q == num_rows_i - ONE);
endmodule

// File: rtl/dense_seq_ctrl.sv
// Sequences weight loads, forward, and optional backprop/update steps into the dense stage.
// Outputs are registered from the next state, so they change only on the edge that enters a state.
module dense_seq_ctrl
  import dense_pkg::*;
#(
  parameter int DSIZE = DATA_SIZE,
  parameter int NELEM = SIZE,
  parameter int MAXL  = MAX_LAYERS,
  parameter int IW    = IDX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   train,
  input  logic [IW-1:0]          num_layers,
  input  logic [IW-1:0]          num_rows,
  output logic                   busy,
  output logic                   done,
  output logic                   w_req,
  output logic [IW-1:0]          w_req_layer,
  output logic [IW-1:0]          w_req_row,
  input  logic                   w_valid,
  input  logic [DSIZE*NELEM-1:0] w_data,
  output logic                   stg_valid,
  input  logic                   stg_ack,
  output logic [DSIZE*NELEM-1:0] w_out,
  output logic [IW-1:0]          w_layer_index,
  output logic [IW-1:0]          w_row_index,
  output logic                   load_w,
  output logic                   is_update,
  output logic                   backprop_cost
);
  localparam int WW = DSIZE * NELEM;

  dense_seq_state_t state_q, state_d;
  logic [WW-1:0]    w_out_q, w_out_d;
  logic [IW-1:0]    nl_q, nl_d, nr_q, nr_d, nl_clamped;
  logic             train_q, train_d;
  logic             busy_q, done_q, w_req_q, stg_valid_q;
  op_t              op_q;
  logic             cnt_clr, cnt_step, cnt_last;
  logic [IW-1:0]    cnt_layer, cnt_row;

  assign nl_clamped = (num_layers > IW'(MAXL)) ? IW'(MAXL) : num_layers;

  dense_idx_counter #(.IW(IW)) u_idx (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (cnt_clr),
    .step_i       (cnt_step),
    .num_layers_i (nl_q),
    .num_rows_i   (nr_q),
    .layer_o      (cnt_layer),
    .row_o        (cnt_row),
    .last_o       (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    w_out_d  = w_out_q;
    train_d  = train_q;
    nl_d     = nl_q;
    nr_d     = nr_q;
    cnt_clr  = 1'b0;
    cnt_step = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        train_d = train;
        nl_d    = nl_clamped;
        nr_d    = num_rows;
        cnt_clr = 1'b1;
        state_d = (nl_clamped == '0 || num_rows == '0) ? S_FWD : S_FETCH;
      end
      S_FETCH: if (w_valid) begin
        w_out_d = w_data;
        state_d = S_ISSUE_W;
      end
      S_ISSUE_W: if (stg_ack) begin
        cnt_step = 1'b1;
        state_d  = cnt_last ? S_FWD : S_FETCH;
      end
      S_FWD:   if (stg_ack) state_d = train_q ? S_BPROP : S_DONE;
      S_BPROP: if (stg_ack) state_d = S_UPD;
      S_UPD:   if (stg_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      w_out_q     <= '0;
      train_q     <= 1'b0;
      nl_q        <= '0;
      nr_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_req_q     <= 1'b0;
      stg_valid_q <= 1'b0;
      op_q        <= OP_NONE;
    end else begin
      state_q     <= state_d;
      w_out_q     <= w_out_d;
      train_q     <= train_d;
      nl_q        <= nl_d;
      nr_q        <= nr_d;
      busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q      <= (state_d == S_DONE);
      w_req_q     <= (state_d == S_FETCH);
      stg_valid_q <= (state_d == S_ISSUE_W) || (state_d == S_FWD) ||
                     (state_d == S_BPROP) || (state_d == S_UPD);
      op_q        <= state_op(state_d);
    end
  end

  // Counters only move on a stage ack, so indices are naturally stable while waiting.
  assign busy          = busy_q;
  assign done          = done_q;
  assign w_req         = w_req_q;
  assign w_req_layer   = cnt_layer;
  assign w_req_row     = cnt_row;
  assign stg_valid     = stg_valid_q;
  assign w_out         = w_out_q;
  assign w_layer_index = cnt_layer;
  assign w_row_index   = cnt_row;
  assign load_w        = op_q[2];
  assign backprop_cost = op_q[1];
  assign is_update     = op_q[0];
endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Randomized bench with a transaction-list model of the expected fetch and stage sequence.
module tb_dense_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, train, w_valid, stg_ack;
  logic [31:0] num_layers, num_rows;
  logic        busy, done, w_req, stg_valid, load_w, is_update, backprop_cost;
  logic [31:0] w_req_layer, w_req_row, w_layer_index, w_row_index;
  logic [47:0] w_data, w_out;

  always #5 clk = ~clk;

  dense_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .train(train),
    .num_layers(num_layers), .num_rows(num_rows),
    .busy(busy), .done(done), .w_req(w_req), .w_req_layer(w_req_layer),
    .w_req_row(w_req_row), .w_valid(w_valid), .w_data(w_data),
    .stg_valid(stg_valid), .stg_ack(stg_ack), .w_out(w_out),
    .w_layer_index(w_layer_index), .w_row_index(w_row_index),
    .load_w(load_w), .is_update(is_update), .backprop_cost(backprop_cost)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: expected stage transactions (0=load,1=fwd,2=bprop,3=upd) and fetches, in order.
  typedef struct { int op; int layer; int row; } stg_e_t;
  typedef struct { int layer; int row; } fet_e_t;
  stg_e_t      stg_q[$];
  fet_e_t      fet_q[$];
  logic [47:0] last_data, issue_wout;
  int          hs_cnt, load_cnt, done_cnt, req_cycles, cyc;
  bit          chk_en;

  function automatic logic [2:0] op_bits(input int op);
    case (op)
      0: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic build_model(input bit t, input int L, input int R);
    int lc;
    lc = (L > 8) ? 8 : L;
    stg_q.delete();
    fet_q.delete();
    if (lc > 0 && R > 0)
      for (int l = 0; l < lc; l++)
        for (int r = 0; r < R; r++) begin
          fet_q.push_back('{l, r});
          stg_q.push_back('{0, l, r});
        end
    stg_q.push_back('{1, 0, 0});
    if (t) begin
      stg_q.push_back('{2, 0, 0});
      stg_q.push_back('{3, 0, 0});
    end
  endtask

  // Responders for the weight source and the stage; -1 delay means random per transaction.
  int          w_delay_mode, ack_delay_mode, wcnt, acnt, wtarget, atarget;
  bit          noise, fixed_data_en;
  logic [47:0] fixed_data;
  logic [63:0] rnd;

  always @(posedge clk) begin
    #1;
    rnd    = {$urandom, $urandom};
    w_data = fixed_data_en ? fixed_data : rnd[47:0];
    if (w_req) begin
      if (wcnt == 0) wtarget = (w_delay_mode < 0) ? $urandom_range(0, 3) : w_delay_mode;
      w_valid = (wcnt == wtarget);
      wcnt    = w_valid ? 0 : wcnt + 1;
    end else begin
      wcnt    = 0;
      w_valid = noise && ($urandom_range(0, 3) == 0);
    end
    if (stg_valid) begin
      if (acnt == 0) atarget = (ack_delay_mode < 0) ? $urandom_range(0, 3) : ack_delay_mode;
      stg_ack = (acnt == atarget);
      acnt    = stg_ack ? 0 : acnt + 1;
    end else begin
      acnt    = 0;
      stg_ack = noise && ($urandom_range(0, 3) == 0);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("op_onehot", 64'($countones({load_w, backprop_cost, is_update}) <= 1), 64'd1);
      chk("busy_done_excl", 64'(busy && done), 64'd0);
      if (!stg_valid) chk("op_when_idle", {load_w, backprop_cost, is_update}, 3'b000);
      if (w_req) begin
        req_cycles++;
        if (fet_q.size() == 0) chk("unexpected_w_req", 64'd1, 64'd0);
        else begin
          chk("req_layer", w_req_layer, 64'(fet_q[0].layer));
          chk("req_row", w_req_row, 64'(fet_q[0].row));
          if (w_valid) begin
            last_data = w_data;
            void'(fet_q.pop_front());
          end
        end
      end
      if (stg_valid) begin
        if (stg_q.size() == 0) chk("unexpected_stg_valid", 64'd1, 64'd0);
        else begin
          chk("stg_op", {load_w, backprop_cost, is_update}, op_bits(stg_q[0].op));
          if (stg_q[0].op == 0) begin
            chk("stg_layer", w_layer_index, 64'(stg_q[0].layer));
            chk("stg_row", w_row_index, 64'(stg_q[0].row));
            chk("stg_wout", w_out, last_data);
          end
          if (stg_ack) begin
            hs_cnt++;
            if (stg_q[0].op == 0) begin
              load_cnt++;
              issue_wout = w_out;
            end
            void'(stg_q.pop_front());
          end
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_model_drained", 64'(stg_q.size() + fet_q.size()), 64'd0);
      end
    end
  end

  task automatic do_start(input bit t, input int L, input int R, output int s);
    build_model(t, L, R);
    hs_cnt = 0; load_cnt = 0; req_cycles = 0;
    @(posedge clk);
    #1 start = 1'b1; train = t; num_layers = L; num_rows = R;
    @(posedge clk);
    #1 start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int s, input bit poke_start, output int done_at);
    bit seen;
    seen = 1'b0;
    done_at = -1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen    = 1'b1;
        done_at = cyc - s + 1;
        if (poke_start) start = 1'b1;
      end
    end
    if (!seen) begin
      chk("done_timeout", 64'd0, 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_cmd(input bit t, input int L, input int R, output int done_at);
    int s;
    do_start(t, L, R, s);
    wait_done(s, 1'b0, done_at);
  endtask

  initial begin
    int d, dc0, s, lc, t, L, R;
    rst_n = 1'b0; start = 1'b1; train = 1'b1; num_layers = 2; num_rows = 2;
    w_valid = 1'b0; stg_ack = 1'b0; w_data = '0; cyc = 0;
    w_delay_mode = 0; ack_delay_mode = 0; noise = 1'b0; fixed_data_en = 1'b0;
    fixed_data = 48'h0003_0002_0001; chk_en = 1'b0; done_cnt = 0;
    wcnt = 0; acnt = 0; wtarget = 0; atarget = 0; last_data = '0; issue_wout = '0;

    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {busy, done, w_req, stg_valid, load_w, is_update, backprop_cost}, 7'd0);
    chk("rst_wout", w_out, 48'd0);
    chk("rst_indices", {w_req_layer, w_req_row, w_layer_index, w_row_index}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("start_in_reset_ignored", {busy, w_req, stg_valid}, 3'd0);
    chk_en = 1'b1;

    // Zero-wait, fwd only, 2x3.
    run_cmd(1'b0, 2, 3, d);
    chk("t1_done_cycle", 64'(d), 64'd14);
    chk("t1_loads", 64'(load_cnt), 64'd6);
    chk("t1_handshakes", 64'(hs_cnt), 64'd7);

    // Training with slow stage; start poked during DONE must be ignored.
    ack_delay_mode = 3;
    dc0 = done_cnt;
    do_start(1'b1, 1, 1, s);
    wait_done(s, 1'b1, d);
    chk("t2_handshakes", 64'(hs_cnt), 64'd4);
    chk("t2_one_done", 64'(done_cnt - dc0), 64'd1);
    @(negedge clk);
    chk("t2_start_in_done_ignored", {busy, w_req, stg_valid}, 3'd0);
    ack_delay_mode = 0;

    // Zero layers: forward only, no fetch.
    run_cmd(1'b0, 0, 3, d);
    chk("t3_no_w_req", 64'(req_cycles), 64'd0);
    chk("t3_handshakes", 64'(hs_cnt), 64'd1);

    // Clamp of 20 layers to 8.
    ack_delay_mode = -1;
    run_cmd(1'b0, 20, 2, d);
    chk("t4_clamped_loads", 64'(load_cnt), 64'd16);
    ack_delay_mode = 0;

    // Slow weight source with a fixed row.
    w_delay_mode = 5; fixed_data_en = 1'b1;
    run_cmd(1'b0, 1, 1, d);
    chk("t5_w_req_cycles", 64'(req_cycles), 64'd6);
    chk("t5_wout", issue_wout, 48'h0003_0002_0001);
    w_delay_mode = 0; fixed_data_en = 1'b0;

    // Reset mid-ISSUE_W aborts without done, then a fresh run starts at (0,0).
    ack_delay_mode = 3;
    dc0 = done_cnt;
    do_start(1'b0, 2, 3, s);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stg_valid && load_w && w_row_index == 1) break;
    end
    chk("t6_reached_issue", 64'(stg_valid && load_w), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    chk("t6_abort_outputs", {busy, done, w_req, stg_valid, load_w, is_update, backprop_cost}, 7'd0);
    chk("t6_abort_wout", w_out, 48'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_no_done", 64'(done_cnt - dc0), 64'd0);
    chk_en = 1'b1;
    ack_delay_mode = 0;
    run_cmd(1'b0, 1, 2, d);
    chk("t6_rerun_loads", 64'(load_cnt), 64'd2);

    // Randomized commands with random latencies and stray handshakes.
    w_delay_mode = -1; ack_delay_mode = -1; noise = 1'b1;
    for (int k = 0; k < 10; k++) begin
      t = $urandom_range(0, 1);
      L = $urandom_range(0, 11);
      R = $urandom_range(0, 3);
      lc = (L > 8) ? 8 : L;
      dc0 = done_cnt;
      run_cmd(t[0], L, R, d);
      chk("rand_handshakes", 64'(hs_cnt), 64'(lc * R + 1 + 2 * t));
      chk("rand_one_done", 64'(done_cnt - dc0), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
